// File: rtl/freq_divbyfrac_param.sv
// Fractional clock divider: output period averages N + M/D input cycles, outputs registered.
// Define FDIV_FRAC_EN to build the fractional accumulator; without it the divider is integer-only.
module freq_divbyfrac_param #(
    parameter int CW = 8,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_int,
    input  logic [FW-1:0] cfg_num,
    input  logic [FW-1:0] cfg_den,
    output logic          cfg_err,
    output logic          clk_div,
    output logic          period_start
);
    localparam logic [CW:0]   LEN_ONE = (CW+1)'(1);
    localparam logic [CW:0]   LEN_DEF = (CW+1)'(2);
    localparam logic [CW-1:0] INT_MIN = CW'(2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] int_reg, int_next;
    logic [CW-1:0] pend_int_reg, pend_int_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW:0]   len_reg, len_next;
    logic [CW:0]   len_cur;
    logic          clk_div_reg, clk_div_next;
    logic          period_start_reg, period_start_next;
    logic          cfg_err_reg, cfg_err_next;
    logic          cfg_ready_reg, cfg_ready_next;

    logic start;
    logic wrap;
    logic offer;
    logic accept;
    logic apply;
    logic cfg_legal;
    logic carry;

    // A period starts on any enabled cycle with the counter at zero; its
    // length is latched there so later cycles of the period need no carry.
    assign start   = en && (cnt_reg == '0);
    assign len_cur = start ? ({1'b0, int_reg} + {{CW{1'b0}}, carry}) : len_reg;
    assign wrap    = en && ({1'b0, cnt_reg} == (len_cur - LEN_ONE));
    assign offer   = cfg_valid && cfg_ready_reg;
    assign accept  = offer && cfg_legal;
    // Pending config exists exactly while cfg_ready is low.
    assign apply   = !cfg_ready_reg && (wrap || !en);

`ifdef FDIV_FRAC_EN
    logic [FW-1:0] num_reg, num_next;
    logic [FW-1:0] den_reg, den_next;
    logic [FW-1:0] pend_num_reg, pend_num_next;
    logic [FW-1:0] pend_den_reg, pend_den_next;
    logic [FW:0]   acc_reg, acc_next;
    logic [FW:0]   acc_sum;

    // acc < den and num < den, so the sum always fits in FW+1 bits.
    assign acc_sum   = acc_reg + {1'b0, num_reg};
    assign carry     = (acc_sum >= {1'b0, den_reg});
    assign cfg_legal = (cfg_int >= INT_MIN) && (cfg_den != '0) && (cfg_num < cfg_den);

    always_comb begin
        num_next      = num_reg;
        den_next      = den_reg;
        pend_num_next = pend_num_reg;
        pend_den_next = pend_den_reg;
        acc_next      = acc_reg;
        if (apply) begin
            num_next = pend_num_reg;
            den_next = pend_den_reg;
            acc_next = '0;
        end else if (start) begin
            acc_next = carry ? (acc_sum - {1'b0, den_reg}) : acc_sum;
        end
        if (accept) begin
            pend_num_next = cfg_num;
            pend_den_next = cfg_den;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_reg      <= '0;
            den_reg      <= FW'(1);
            pend_num_reg <= '0;
            pend_den_reg <= FW'(1);
            acc_reg      <= '0;
        end else begin
            num_reg      <= num_next;
            den_reg      <= den_next;
            pend_num_reg <= pend_num_next;
            pend_den_reg <= pend_den_next;
            acc_reg      <= acc_next;
        end
    end
`else
    logic cfg_frac_unused;

    assign cfg_frac_unused = ^{cfg_num, cfg_den};
    assign carry           = 1'b0;
    assign cfg_legal       = (cfg_int >= INT_MIN);
`endif

    always_comb begin
        cnt_next          = (!en || wrap) ? '0 : (cnt_reg + CNT_ONE);
        len_next          = start ? len_cur : len_reg;
        // High for the first floor(L/2) cycles, low for the rest.
        clk_div_next      = en && ({1'b0, cnt_reg} < (len_cur >> 1));
        period_start_next = start;
        cfg_err_next      = offer && !cfg_legal;
        cfg_ready_next    = cfg_ready_reg;
        int_next          = int_reg;
        pend_int_next     = pend_int_reg;
        if (accept) begin
            pend_int_next  = cfg_int;
            cfg_ready_next = 1'b0;
        end
        if (apply) begin
            int_next       = pend_int_reg;
            cfg_ready_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_reg          <= INT_MIN;
            pend_int_reg     <= INT_MIN;
            cnt_reg          <= '0;
            len_reg          <= LEN_DEF;
            clk_div_reg      <= 1'b0;
            period_start_reg <= 1'b0;
            cfg_err_reg      <= 1'b0;
            cfg_ready_reg    <= 1'b1;
        end else begin
            int_reg          <= int_next;
            pend_int_reg     <= pend_int_next;
            cnt_reg          <= cnt_next;
            len_reg          <= len_next;
            clk_div_reg      <= clk_div_next;
            period_start_reg <= period_start_next;
            cfg_err_reg      <= cfg_err_next;
            cfg_ready_reg    <= cfg_ready_next;
        end
    end

    assign clk_div      = clk_div_reg;
    assign period_start = period_start_reg;
    assign cfg_err      = cfg_err_reg;
    assign cfg_ready    = cfg_ready_reg;

endmodule

// File: doc/freq_divbyfrac_param.md
FREQ_DIVBYFRAC_PARAM -- requirements
Module: freq_divbyfrac_param

Interface
REQ-001 SHALL have parameter CW, default 8: width of the integer divide field.
REQ-002 SHALL have parameter FW, default 8: width of the fractional numerator and denominator fields.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run enable.
REQ-006 cfg_valid  input  1  config offer.
REQ-007 cfg_ready  output  1  config accept-ready.
REQ-008 cfg_int  input  CW  integer divisor N (legal range N >= 2).
REQ-009 cfg_num  input  FW  fractional numerator M.
REQ-010 cfg_den  input  FW  fractional denominator D; divide ratio is N + M/D.
REQ-011 cfg_err  output  1  one-cycle pulse when an offered config is rejected.
REQ-012 clk_div  output  1  divided clock, registered.
REQ-013 period_start  output  1  one-cycle pulse on the first cycle of each output period.

Function
REQ-014 SHALL hold active registers int_r, num_r and den_r, plus a period counter cnt and an accumulator acc of width FW+1.
REQ-015 At each period start, SHALL compute s = acc + num_r; if s >= den_r then carry=1 and acc = s - den_r, else carry=0 and acc = s.
REQ-016 Period length SHALL be L = int_r + carry; cnt SHALL count 0..L-1, then wrap to 0, which begins the next period.
REQ-017 clk_div SHALL be 1 for the first floor(L/2) cycles of each period and 0 for the remaining ceil(L/2) cycles.
REQ-018 period_start SHALL be 1 exactly on cycles where cnt = 0 and en = 1.
REQ-019 The first period SHALL begin on the first cycle with en = 1 after reset release or after en rises.
REQ-020 en = 0 SHALL force cnt = 0 and clk_div = 0 on the next edge; acc SHALL be held.
REQ-021 A config SHALL be accepted when cfg_valid && cfg_ready; the accepted fields go into pending registers and cfg_ready drops to 0.
REQ-022 Pending config SHALL be applied at the next period boundary, or on the next edge if en = 0.
REQ-023 On apply, SHALL set acc = 0 and cfg_ready = 1; the new L takes effect from that period.
REQ-024 A config accepted on the same cycle as a boundary SHALL apply at the following boundary, not the current one.
REQ-025 A config is illegal if cfg_int < 2, cfg_den = 0, or cfg_num >= cfg_den.
REQ-026 An illegal config SHALL be rejected: cfg_err pulses for 1 cycle, cfg_ready stays 1, and active and pending registers are unchanged.
REQ-027 While cfg_ready = 0, cfg_valid SHALL be ignored and cfg_err SHALL not pulse.

Reset
REQ-028 While rst = 1, on each edge: int_r=2, num_r=0, den_r=1, cnt=0, acc=0, clk_div=0, period_start=0, cfg_err=0, cfg_ready=1.
REQ-029 Reset mid-operation SHALL discard any pending config and abort the current period.

Configuration
REQ-030 Macro FDIV_FRAC_EN SHALL control compilation of the fractional datapath.
REQ-031 With FDIV_FRAC_EN defined: behaviour per REQ-015..REQ-026.
REQ-032 Without FDIV_FRAC_EN: acc logic is omitted, carry is always 0, and cfg_num/cfg_den are ignored (ports kept). The only illegal condition is cfg_int < 2.

Verification
REQ-033 Reset release, en=1, no cfg -> L=2; clk_div 1,0,1,0...; period_start every 2 cycles.
REQ-034 cfg N=3, M=1, D=2 -> period lengths alternate 3,4,3,4 (7 cycles per pair); high time 1 then 2 cycles.
REQ-035 cfg N=4, M=0, D=1 -> constant L=4; clk_div 1,1,0,0 repeating.
REQ-036 cfg N=5, D=0 -> cfg_err 1-cycle pulse; cfg_ready stays 1; output ratio unchanged.
REQ-037 Cfg offered mid-period -> cfg_ready=0 until boundary; new L from the next period; acc restarts at 0.
REQ-038 en dropped mid-period and rst asserted mid-period -> clk_div=0 next cycle; after rst, pending config discarded and default L=2 resumes.
